// File: rtl/collector.sv
// Capture side of the codec datapath: pairs left/right ADC samples and writes them into a
// 4-window circular sample RAM. Define COLLECTOR_MONO_MIX_EN to store floor((L+R)/2) instead of L.
module collector #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned WINDOW_LEN = 512,
   parameter int unsigned ADDR_W     = $clog2(WINDOW_LEN) + 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [WIDTH-1:0]  left_in_data,
   input  logic              left_in_valid,
   output logic              left_in_ready,
   input  logic [WIDTH-1:0]  right_in_data,
   input  logic              right_in_valid,
   output logic              right_in_ready,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [WIDTH-1:0]  buf_data,
   output logic              buf_wren,
   input  logic              hold_valid,
   input  logic [1:0]        hold_window,
   output logic [1:0]        window_start,
   output logic              go_out
);

   localparam int unsigned OFF_W = ADDR_W - 2;

   typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic              have_l;
   logic              have_r;
   logic [WIDTH-1:0]  left_q;

   logic              blocked;
   logic              left_xfer;
   logic              right_xfer;
   logic              pair_done;
   logic [WIDTH-1:0]  left_nxt;
   logic [WIDTH-1:0]  sample;

   assign blocked        = hold_valid && (hold_window == wr_ptr[ADDR_W-1 -: 2]);
   assign left_in_ready  = (state == StCollect) && !have_l && !blocked;
   assign right_in_ready = (state == StCollect) && !have_r && !blocked;
   assign left_xfer      = left_in_valid && left_in_ready;
   assign right_xfer     = right_in_valid && right_in_ready;
   // Pair completes in the same cycle the second half arrives, so the write lands one cycle later.
   assign pair_done      = (have_l || left_xfer) && (have_r || right_xfer);
   assign left_nxt       = left_xfer ? left_in_data : left_q;

`ifdef COLLECTOR_MONO_MIX_EN
   logic [WIDTH-1:0]      right_q;
   logic [WIDTH-1:0]      right_nxt;
   logic signed [WIDTH:0] sum;

   assign right_nxt = right_xfer ? right_in_data : right_q;
   assign sum       = $signed({left_nxt[WIDTH-1], left_nxt}) +
                      $signed({right_nxt[WIDTH-1], right_nxt});
   assign sample    = WIDTH'(sum >>> 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         right_q <= '0;
      end else if (right_xfer) begin
         right_q <= right_in_data;
      end
   end
`else
   logic unused_right;

   assign unused_right = ^right_in_data;
   assign sample       = left_nxt;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= StIdle;
         wr_ptr       <= '0;
         have_l       <= 1'b0;
         have_r       <= 1'b0;
         left_q       <= '0;
         buf_addr     <= '0;
         buf_data     <= '0;
         buf_wren     <= 1'b0;
         window_start <= 2'd0;
         go_out       <= 1'b0;
      end else begin
         buf_wren <= 1'b0;
         go_out   <= 1'b0;
         if (left_xfer) begin
            left_q <= left_in_data;
            have_l <= 1'b1;
         end
         if (right_xfer) begin
            have_r <= 1'b1;
         end
         case (state)
            StIdle: begin
               if (enable) begin
                  state <= StCollect;
               end
            end
            StCollect: begin
               if (!enable) begin
                  // Abort: partial pair and partial window are dropped.
                  state  <= StIdle;
                  have_l <= 1'b0;
                  have_r <= 1'b0;
                  wr_ptr <= '0;
               end else if (pair_done) begin
                  state    <= StWrite;
                  buf_wren <= 1'b1;
                  buf_addr <= wr_ptr;
                  buf_data <= sample;
               end
            end
            StWrite: begin
               have_l <= 1'b0;
               have_r <= 1'b0;
               if (wr_ptr[OFF_W-1:0] == OFF_W'(WINDOW_LEN - 1)) begin
                  go_out       <= 1'b1;
                  window_start <= wr_ptr[ADDR_W-1 -: 2];
               end
               if (enable) begin
                  wr_ptr <= wr_ptr + ADDR_W'(1);
                  state  <= StCollect;
               end else begin
                  wr_ptr <= '0;
                  state  <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_collector.sv
// Directed bench for collector (WINDOW_LEN=4) with a cycle-level reference model and literal pins.
module tb_collector;

   localparam int WL = 4;
   localparam int AW = 4;

   logic          clk;
   logic          reset_n;
   logic          enable;
   logic [15:0]   left_in_data;
   logic          left_in_valid;
   logic          left_in_ready;
   logic [15:0]   right_in_data;
   logic          right_in_valid;
   logic          right_in_ready;
   logic [AW-1:0] buf_addr;
   logic [15:0]   buf_data;
   logic          buf_wren;
   logic          hold_valid;
   logic [1:0]    hold_window;
   logic [1:0]    window_start;
   logic          go_out;

   int n_checks = 0;
   int n_err    = 0;

   logic [1:0] go_log[$];

   collector #(
      .WIDTH      (16),
      .WINDOW_LEN (WL),
      .ADDR_W     (AW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .enable         (enable),
      .left_in_data   (left_in_data),
      .left_in_valid  (left_in_valid),
      .left_in_ready  (left_in_ready),
      .right_in_data  (right_in_data),
      .right_in_valid (right_in_valid),
      .right_in_ready (right_in_ready),
      .buf_addr       (buf_addr),
      .buf_data       (buf_data),
      .buf_wren       (buf_wren),
      .hold_valid     (hold_valid),
      .hold_window    (hold_window),
      .window_start   (window_start),
      .go_out         (go_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // m_state: 0 idle, 1 collecting, 2 writing
   int          m_state;
   bit          m_hl, m_hr;
   logic [15:0] m_l;
   int          m_ptr;
   bit          m_go;
   int          m_ws;
   logic [15:0] m_wdata;
`ifdef COLLECTOR_MONO_MIX_EN
   logic [15:0] m_r;

   function automatic logic [15:0] floor_avg(input logic [15:0] l, input logic [15:0] r);
      int s;
      s = int'($signed(l)) + int'($signed(r));
      if (s < 0 && (s % 2) != 0) return 16'((s - 1) / 2);
      return 16'(s / 2);
   endfunction
`endif

   function automatic bit m_blocked();
      return hold_valid && (int'(hold_window) == m_ptr / WL);
   endfunction

   task automatic model_clear();
      m_state = 0; m_hl = 0; m_hr = 0; m_l = '0; m_ptr = 0;
      m_go = 0; m_ws = 0; m_wdata = '0;
   endtask

   task automatic model_step();
      bit lx, rx, go_n;
      go_n = 0;
      lx = (m_state == 1) && !m_hl && !m_blocked() && left_in_valid;
      rx = (m_state == 1) && !m_hr && !m_blocked() && right_in_valid;
      case (m_state)
         0: if (enable) m_state = 1;
         1: begin
            if (!enable) begin
               m_state = 0; m_hl = 0; m_hr = 0; m_ptr = 0;
            end else begin
               if (lx) begin m_hl = 1; m_l = left_in_data; end
`ifdef COLLECTOR_MONO_MIX_EN
               if (rx) begin m_hr = 1; m_r = right_in_data; end
`else
               if (rx) m_hr = 1;
`endif
               if (m_hl && m_hr) begin
                  m_state = 2;
`ifdef COLLECTOR_MONO_MIX_EN
                  m_wdata = floor_avg(m_l, m_r);
`else
                  m_wdata = m_l;
`endif
               end
            end
         end
         default: begin
            if (m_ptr % WL == WL - 1) begin go_n = 1; m_ws = m_ptr / WL; end
            m_hl = 0; m_hr = 0;
            if (enable) begin m_ptr = (m_ptr + 1) % (4 * WL); m_state = 1; end
            else begin m_ptr = 0; m_state = 0; end
         end
      endcase
      m_go = go_n;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_clear();
         else model_step();
      end
   end

   // Compare DUT against the model every cycle, mid-period.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            check("left_in_ready", left_in_ready, (m_state == 1) && !m_hl && !m_blocked());
            check("right_in_ready", right_in_ready, (m_state == 1) && !m_hr && !m_blocked());
            check("buf_wren", buf_wren, m_state == 2);
            if (m_state == 2) begin
               check("buf_addr", buf_addr, m_ptr);
               check("buf_data", buf_data, m_wdata);
            end
            check("go_out", go_out, m_go);
            if (m_go) check("window_start", window_start, m_ws);
            if (go_out) go_log.push_back(window_start);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present a pair; each half is held until accepted. Returns in the write cycle.
   task automatic send(input logic [15:0] l, input logic [15:0] r);
      bit pl = 1, pr = 1, lx, rx;
      int n = 0;
      while ((pl || pr) && n < 20) begin
         left_in_valid  = pl; left_in_data  = l;
         right_in_valid = pr; right_in_data = r;
         @(negedge clk);
         lx = pl && left_in_ready;
         rx = pr && right_in_ready;
         tick();
         if (lx) pl = 0;
         if (rx) pr = 0;
         n++;
      end
      left_in_valid  = 0;
      right_in_valid = 0;
      if (pl || pr) begin
         n_checks++;
         n_err++;
         $display("FAIL send_timeout: pair %0h/%0h not accepted within 20 cycles", l, r);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_lrdy"}, left_in_ready, 0);
      check({tag, "_rrdy"}, right_in_ready, 0);
      check({tag, "_wren"}, buf_wren, 0);
      check({tag, "_addr"}, buf_addr, 0);
      check({tag, "_data"}, buf_data, 0);
      check({tag, "_go"}, go_out, 0);
      check({tag, "_ws"}, window_start, 0);
   endtask

   function automatic logic [15:0] pick(input logic [15:0] mixed, input logic [15:0] left);
`ifdef COLLECTOR_MONO_MIX_EN
      return mixed + 16'(0 * left);
`else
      return left + 16'(0 * mixed);
`endif
   endfunction

   initial begin
      reset_n = 0; enable = 0; hold_valid = 0; hold_window = 2'd0;
      left_in_valid = 0; right_in_valid = 0; left_in_data = '0; right_in_data = '0;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      tick();
      reset_n = 1;
      enable  = 1;

      // Pairing and latency: cycle 0 is the first cycle out of reset.
      tick(); tick();
      left_in_valid = 1; left_in_data = 16'h0010;            // cycle 3
      @(negedge clk); check("t1_lrdy_c3", left_in_ready, 1);
      tick(); left_in_valid = 0;                            // cycle 4
      @(negedge clk); check("t1_lrdy_c4", left_in_ready, 0);
      tick(); right_in_valid = 1; right_in_data = 16'h0030; // cycle 5
      @(negedge clk);
      check("t1_lrdy_c5", left_in_ready, 0);
      check("t1_wren_c5", buf_wren, 0);
      tick(); right_in_valid = 0;                           // cycle 6
      @(negedge clk);
      check("t1_wren_c6", buf_wren, 1);
      check("t1_addr_c6", buf_addr, 0);
      check("t1_data_c6", buf_data, pick(16'h0020, 16'h0010));
      tick();                                               // cycle 7
      @(negedge clk); check("t1_wren_c7", buf_wren, 0);
      tick();

      // Mix arithmetic at the extremes; the third write closes window 0.
      send(16'h7FFF, 16'h7FFF);
      @(negedge clk); check("mix_max", buf_data, pick(16'h7FFF, 16'h7FFF));
      tick();
      send(16'h8000, 16'h8000);
      @(negedge clk); check("mix_min", buf_data, pick(16'h8000, 16'h8000));
      tick();
      send(16'h0001, 16'hFFFE);
      @(negedge clk);
      check("mix_neg_floor", buf_data, pick(16'hFFFF, 16'h0001));
      check("mix_addr3", buf_addr, 3);
      tick();
      @(negedge clk);
      check("go_win0", go_out, 1);
      check("go_win0_ws", window_start, 0);
      tick();

      // Fill windows 1..3, then wrap.
      for (int i = 4; i < 16; i++) send(16'(i * 257), 16'(i * 3));
      send(16'h1234, 16'h4321);
      @(negedge clk);
      check("wrap_addr", buf_addr, 0);
      check("wrap_data", buf_data, pick(16'h2AAA, 16'h1234));
      check("go_count_4", go_log.size(), 4);
      for (int i = 0; i < 4 && i < go_log.size(); i++) check("go_seq", go_log[i], i);
      tick();

      // Consumer holds window 1 while window 0 completes.
      hold_valid = 1; hold_window = 2'd1;
      send(16'h0011, 16'h0022);
      send(16'h0033, 16'h0044);
      send(16'h0055, 16'h0066);
      tick();
      left_in_valid = 1; left_in_data = 16'h0100;
      right_in_valid = 1; right_in_data = 16'h0300;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("hold_lrdy", left_in_ready, 0);
         check("hold_rrdy", right_in_ready, 0);
         check("hold_wren", buf_wren, 0);
         tick();
      end
      hold_valid = 0;
      @(negedge clk);
      check("unhold_lrdy", left_in_ready, 1);
      check("unhold_rrdy", right_in_ready, 1);
      tick();
      left_in_valid = 0; right_in_valid = 0;
      @(negedge clk);
      check("unhold_wren", buf_wren, 1);
      check("unhold_addr", buf_addr, 4);
      check("unhold_data", buf_data, pick(16'h0200, 16'h0100));
      check("go_count_5", go_log.size(), 5);
      tick();

      // Enable drop with a left half held at offset 2.
      send(16'h0AAA, 16'h0555);
      tick();
      left_in_valid = 1; left_in_data = 16'h0777;
      @(negedge clk); check("abort_lrdy", left_in_ready, 1);
      tick(); left_in_valid = 0; enable = 0;
      @(negedge clk); check("abort_lrdy_held", left_in_ready, 0);
      tick();
      @(negedge clk); check("abort_idle_rrdy", right_in_ready, 0);
      tick(); enable = 1;
      tick();
      send(16'h0040, 16'h0020);
      @(negedge clk);
      check("reenable_addr", buf_addr, 0);
      check("reenable_data", buf_data, pick(16'h0030, 16'h0040));
      tick(); tick();
      check("abort_no_go", go_log.size(), 5);

      // Async reset between the window's last write and its go cycle.
      send(16'h0001, 16'h0001);
      send(16'h0002, 16'h0002);
      send(16'h0003, 16'h0003);
      check("pre_reset_wren", buf_wren, 1);
      #1 reset_n = 0;
      #1 check_all_zero("async");
      @(posedge clk);
      #1 check("reset_go", go_out, 0);
      @(posedge clk);
      #2 reset_n = 1;
      send(16'h0005, 16'h0007);
      @(negedge clk);
      check("post_reset_addr", buf_addr, 0);
      check("post_reset_data", buf_data, pick(16'h0006, 16'h0005));
      tick(); tick(); tick();
      check("reset_lost_go", go_log.size(), 5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/collector.md
Name: collector

Overview:
- Receive side of the Wolfson audio CODEC datapath, the counterpart of the DAC-side writer.
- Accepts left and right samples from the codec's Avalon-ST from_adc sources and pairs them into one mono sample.
- Writes each sample into a 4-window circular sample RAM.
- Pulses go_out with the index of each completed window, so the stitcher/pitch stage can start processing it.

Parameters:
- WIDTH, 16, sample width in bits, two's complement.
- WINDOW_LEN, 512, samples per window; must be a power of 2 and at least 2.
- ADDR_W, $clog2(WINDOW_LEN)+2, sample RAM address width, covering 4 windows.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = capture audio.
- left_in_data  in  WIDTH  codec left from_adc data.
- left_in_valid  in  1  codec left valid.
- left_in_ready  out  1  collector ready for left.
- right_in_data  in  WIDTH  codec right from_adc data.
- right_in_valid  in  1  codec right valid.
- right_in_ready  out  1  collector ready for right.
- buf_addr  out  ADDR_W  sample RAM write address.
- buf_data  out  WIDTH  sample RAM write data.
- buf_wren  out  1  sample RAM write enable.
- hold_valid  in  1  consumer currently owns a window.
- hold_window  in  2  index of the window the consumer owns.
- window_start  out  2  index of the completed window; valid while go_out=1.
- go_out  out  1  one-cycle pulse: window complete.

Behaviour:
- Reset: asynchronous on reset_n=0. All outputs go to 0, state=IDLE, wr_ptr=0, have_l=have_r=0, held samples cleared.
- wr_ptr: ADDR_W bits. Window index = wr_ptr[ADDR_W-1:ADDR_W-2]; offset = the remaining low bits.
- blocked = hold_valid && (hold_window == window index of wr_ptr).
- IDLE state:
  - Both readies are 0 and buf_wren is 0.
  - enable=1 moves to COLLECT on the next edge.
- COLLECT state:
  - left_in_ready = !have_l && !blocked; right_in_ready = !have_r && !blocked.
  - A transfer happens when valid && ready. It latches the sample and sets have_l or have_r.
  - Left and right may both transfer in the same cycle.
  - have_l && have_r moves to WRITE.
- WRITE state (exactly 1 cycle):
  - buf_wren=1, buf_addr=wr_ptr, buf_data=mix; both readies are 0.
  - have_l and have_r are cleared and wr_ptr increments, wrapping 4*WINDOW_LEN-1 -> 0.
  - If the offset written was WINDOW_LEN-1, the next cycle has go_out=1 and window_start = index of the window just written. go_out lasts exactly one cycle.
  - Then go to COLLECT, or to IDLE if enable=0.
- Latency: when the second half of a pair transfers in cycle N, buf_wren is asserted in cycle N+1. go_out for the final sample of a window is asserted in cycle N+2.
- Mix: 17-bit signed sum L+R, arithmetic shift right by 1 (floor), truncated to WIDTH. This can never overflow.
- blocked while waiting: readies are held at 0 and any already-held half sample is retained. Capture resumes the cycle after blocked falls; no sample is written into a held window. Back-pressure is absorbed by the codec FIFO.
- enable falls during COLLECT:
  - Go to IDLE next edge; a partially held pair is discarded.
  - wr_ptr is cleared to 0 and no go_out is issued for a partial window.
- enable falls during WRITE: the write completes, including any resulting go_out, then the block enters IDLE with wr_ptr=0.
- reset_n asserted mid-operation: immediate return to reset values. A pending go_out is lost.

Optional Feature:
- Macro: COLLECTOR_MONO_MIX_EN.
- Defined: buf_data = floor((L+R)/2) as described above.
- Undefined: buf_data = latched left sample. Right samples are still handshaked and pair-gated, so channel alignment and timing are identical, but right data is discarded.

Test Plan:
- Pairing and latency, WINDOW_LEN=4, enable=1, mix enabled:
  - left 0x0010 valid in cycle 3, right 0x0030 valid in cycle 5.
  - Required: buf_wren=1 in cycle 6 only, buf_addr=0, buf_data=0x0020; left_in_ready=0 in cycles 4-5.
- Mix arithmetic: pairs (0x7FFF,0x7FFF), (0x8000,0x8000), (0x0001,0xFFFE) -> buf_data 0x7FFF, 0x8000, 0xFFFF.
- Window completion and wrap, WINDOW_LEN=4:
  - Stream 16 pairs -> go_out pulses 4 times with window_start 0,1,2,3, each 1 cycle after the write to addr 3, 7, 11, 15.
  - The 17th pair writes addr 0.
- Consumer hold: hold_valid=1, hold_window=1 while window 0 completes -> both readies stay 0 and no write to addr 4. Dropping hold_valid restores ready next cycle and the first write goes to addr 4.
- Enable drop: deassert enable after left-only transfer at offset 2 -> IDLE. Re-enable; the next pair writes addr 0 and no go_out occurs for the aborted window.
- Async reset: assert reset_n=0 between the last WRITE of a window and its go_out cycle -> all outputs 0 immediately, no go_out pulse, first write after release goes to addr 0.
